// File: rtl/game_pkg.sv
// game_pkg: shared definitions for the game tick timer.
//   - speed codes produced by the level-select stage
//   - tick timer FSM state encoding
//   - default period / round constants (50 MHz system clock)
//   - helper that maps the unused speed code onto normal speed
package game_pkg;

    localparam logic [1:0] SPD_NORMAL = 2'b00;
    localparam logic [1:0] SPD_INTER  = 2'b01;
    localparam logic [1:0] SPD_ADV    = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int DEF_PERIOD_NORMAL = 50000000;
    localparam int DEF_PERIOD_INTER  = 25000000;
    localparam int DEF_PERIOD_ADV    = 12500000;
    localparam int DEF_NUM_TICKS     = 30;
    localparam int DEF_CNT_W         = 26;
    localparam int DEF_TL_W          = 5;

    // Code 2'b11 is not a real speed; treat it as normal so a glitchy
    // selector never produces an undefined period.
    function automatic logic [1:0] sanitize_speed(input logic [1:0] spd);
        return (spd == 2'b11) ? SPD_NORMAL : spd;
    endfunction

endpackage

// File: rtl/game_tick_timer_tick_prescaler.sv
// tick_prescaler: free-running cycle counter that flags the last cycle of
// each tick period.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   period    - cycles per tick (counter runs 0 .. period-1)
//   enable    - advance the counter this cycle (low = freeze)
//   clear     - force the counter back to 0 (wins over enable)
//   tc        - high while enabled and the count sits at period-1
module tick_prescaler #(
    parameter int CNT_W = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] period,
    input  logic             enable,
    input  logic             clear,
    output logic             tc
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Equality compare: the period is stable while counting, so the
    // counter can never step past period-1.
    assign tc = enable && (count_q == (period - CNT_W'(1)));

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (tc) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/game_tick_timer.sv
// game_tick_timer: once armed by control, emits NUM_TICKS one-cycle tick
// pulses spaced by the period of the latched game speed, counting the
// remaining ticks down and flagging round completion.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   gameSpeed  - speed code, latched when the round is armed
//   control    - level arm: high runs/holds a round, low returns to IDLE
//   hold       - pause; freezes the prescaler and defers any tick
//   tick       - one-cycle pulse per game tick (registered)
//   ticksLeft  - ticks remaining in the round (registered)
//   running    - high while in RUN (registered)
//   done       - high while in DONE (registered)
//   state_dbg  - current FSM state, for observation
module game_tick_timer
    import game_pkg::*;
#(
    parameter int PERIOD_NORMAL = DEF_PERIOD_NORMAL,
    parameter int PERIOD_INTER  = DEF_PERIOD_INTER,
    parameter int PERIOD_ADV    = DEF_PERIOD_ADV,
    parameter int NUM_TICKS     = DEF_NUM_TICKS,
    parameter int CNT_W         = DEF_CNT_W,
    parameter int TL_W          = DEF_TL_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      gameSpeed,
    input  logic            control,
    input  logic            hold,
    output logic            tick,
    output logic [TL_W-1:0] ticksLeft,
    output logic            running,
    output logic            done,
    output logic [1:0]      state_dbg
);

    localparam logic [CNT_W-1:0] P_NORMAL = CNT_W'(PERIOD_NORMAL);
    localparam logic [CNT_W-1:0] P_INTER  = CNT_W'(PERIOD_INTER);
    localparam logic [CNT_W-1:0] P_ADV    = CNT_W'(PERIOD_ADV);
    localparam logic [TL_W-1:0]  TICKS_INIT = TL_W'(NUM_TICKS);

    state_t          state_q, state_d;
    logic [1:0]      speed_lat_q, speed_lat_d;
    logic            tick_q, tick_d;
    logic [TL_W-1:0] ticks_left_q, ticks_left_d;
    logic            running_q, running_d;
    logic            done_q, done_d;

    logic [CNT_W-1:0] period;
    logic             pre_enable;
    logic             pre_clear;
    logic             pre_tc;

    always_comb begin
        period = P_NORMAL;
        case (speed_lat_q)
            SPD_INTER: period = P_INTER;
            SPD_ADV:   period = P_ADV;
            default:   period = P_NORMAL;
        endcase
    end

    // The prescaler only counts inside an active round. Dropping control
    // clears it on the same edge the FSM leaves RUN, so a terminal count
    // coinciding with the drop never yields a tick.
    assign pre_enable = (state_q == RUN) && control && !hold;
    assign pre_clear  = !((state_q == RUN) && control);

    tick_prescaler #(
        .CNT_W (CNT_W)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .period (period),
        .enable (pre_enable),
        .clear  (pre_clear),
        .tc     (pre_tc)
    );

    always_comb begin
        state_d      = state_q;
        speed_lat_d  = speed_lat_q;
        tick_d       = 1'b0;
        ticks_left_d = ticks_left_q;
        running_d    = running_q;
        done_d       = done_q;

        case (state_q)
            IDLE: begin
                ticks_left_d = '0;
                running_d    = 1'b0;
                done_d       = 1'b0;
                if (control) begin
                    speed_lat_d  = sanitize_speed(gameSpeed);
                    ticks_left_d = TICKS_INIT;
                    running_d    = 1'b1;
                    state_d      = RUN;
                end
            end
            RUN: begin
                if (!control) begin
                    state_d      = IDLE;
                    ticks_left_d = '0;
                    running_d    = 1'b0;
                    done_d       = 1'b0;
                end else if (pre_tc) begin
                    tick_d       = 1'b1;
                    ticks_left_d = (ticks_left_q != '0) ? ticks_left_q - TL_W'(1) : '0;
                    // Final tick: completion flags move on the same edge.
                    if (ticks_left_q <= TL_W'(1)) begin
                        state_d   = DONE;
                        running_d = 1'b0;
                        done_d    = 1'b1;
                    end
                end
            end
            DONE: begin
                ticks_left_d = '0;
                running_d    = 1'b0;
                done_d       = 1'b1;
                if (!control) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                end
            end
            default: begin
                state_d      = IDLE;
                ticks_left_d = '0;
                running_d    = 1'b0;
                done_d       = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            speed_lat_q  <= SPD_NORMAL;
            tick_q       <= 1'b0;
            ticks_left_q <= '0;
            running_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            speed_lat_q  <= speed_lat_d;
            tick_q       <= tick_d;
            ticks_left_q <= ticks_left_d;
            running_q    <= running_d;
            done_q       <= done_d;
        end
    end

    assign tick      = tick_q;
    assign ticksLeft = ticks_left_q;
    assign running   = running_q;
    assign done      = done_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_game_tick_timer.sv
// Directed bench for game_tick_timer with short periods
// (normal=8, inter=4, adv=2, 3 ticks per round).
module tb_game_tick_timer;
    import game_pkg::*;

    localparam int TL_W = 2;
    localparam int CNT_W = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    logic [1:0] game_speed;
    logic control;
    logic hold;
    logic tick;
    logic [TL_W-1:0] ticks_left;
    logic running;
    logic done;
    logic [1:0] state_dbg;

    always #5 clk = ~clk;

    game_tick_timer #(
        .PERIOD_NORMAL (8),
        .PERIOD_INTER  (4),
        .PERIOD_ADV    (2),
        .NUM_TICKS     (3),
        .CNT_W         (CNT_W),
        .TL_W          (TL_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .gameSpeed (game_speed),
        .control   (control),
        .hold      (hold),
        .tick      (tick),
        .ticksLeft (ticks_left),
        .running   (running),
        .done      (done),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad = 0;
    logic [TL_W-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one clock edge, then settle before looking at outputs / driving inputs
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // {tick, running, done, ticksLeft} packed for one-shot checks
    function automatic logic [31:0] outs();
        return 32'({tick, running, done, ticks_left});
    endfunction

    function automatic logic [31:0] pack(input logic t, input logic r, input logic d, input logic [TL_W-1:0] tl);
        return 32'({t, r, d, tl});
    endfunction

    // After the arming edge: expect each of the three ticks exactly p
    // cycles apart, with ticksLeft taken from the expected queue.
    task automatic run_round(input string tag, input int p);
        logic [TL_W-1:0] e;
        exp_q = {2'd2, 2'd1, 2'd0};
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < p - 1; c++) begin
                step();
                chk({tag, "_gap"}, 32'(tick), 32'd0);
            end
            step();
            e = exp_q.pop_front();
            chk({tag, "_tick"}, outs(), pack(1'b1, e != 0, e == 0, e));
        end
        step();
        chk({tag, "_after"}, outs(), pack(1'b0, 1'b0, 1'b1, 2'd0));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1;
        game_speed = 2'b00;
        control = 1'b0;
        hold = 1'b0;
        step();
        step();
        chk("reset_outs", outs(), 32'd0);
        chk("reset_state", 32'(state_dbg), 32'(IDLE));
        rst = 1'b0;
        step();
        chk("idle_outs", outs(), 32'd0);

        // Test 1: advanced speed, period 2
        game_speed = 2'b10;
        control = 1'b1;
        step();
        chk("t1_arm", outs(), pack(1'b0, 1'b1, 1'b0, 2'd3));
        chk("t1_state", 32'(state_dbg), 32'(RUN));
        run_round("t1", 2);

        // Test 6: DONE persists while control stays high
        for (int i = 0; i < 50; i++) begin
            step();
            chk("t6_done_hold", outs(), pack(1'b0, 1'b0, 1'b1, 2'd0));
        end
        chk("t6_state", 32'(state_dbg), 32'(DONE));

        control = 1'b0;
        step();
        chk("t1_to_idle", outs(), 32'd0);

        // Test 2: normal speed, then the 2'b11 code with identical timing
        game_speed = 2'b00;
        control = 1'b1;
        step();
        chk("t2_arm", outs(), pack(1'b0, 1'b1, 1'b0, 2'd3));
        run_round("t2_norm", 8);
        control = 1'b0;
        step();
        game_speed = 2'b11;
        control = 1'b1;
        step();
        chk("t2b_arm", outs(), pack(1'b0, 1'b1, 1'b0, 2'd3));
        run_round("t2_code11", 8);
        control = 1'b0;
        step();

        // Test 3: intermediate, speed change ignored, hold at terminal count
        game_speed = 2'b01;
        control = 1'b1;
        step();
        game_speed = 2'b10;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("t3_gap1", 32'(tick), 32'd0);
        end
        step();
        chk("t3_tick1", outs(), pack(1'b1, 1'b1, 1'b0, 2'd2));
        for (int c = 0; c < 3; c++) begin
            step();
            chk("t3_gap2", 32'(tick), 32'd0);
        end
        hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("t3_held", outs(), pack(1'b0, 1'b1, 1'b0, 2'd2));
        end
        hold = 1'b0;
        step();
        chk("t3_tick2_late", outs(), pack(1'b1, 1'b1, 1'b0, 2'd1));
        for (int c = 0; c < 3; c++) begin
            step();
            chk("t3_gap3", 32'(tick), 32'd0);
        end
        step();
        chk("t3_tick3", outs(), pack(1'b1, 1'b0, 1'b1, 2'd0));
        control = 1'b0;
        step();

        // Test 4: control drops exactly at a terminal count
        game_speed = 2'b01;
        control = 1'b1;
        step();
        for (int c = 0; c < 3; c++) step();
        step();
        chk("t4_tick1", outs(), pack(1'b1, 1'b1, 1'b0, 2'd2));
        for (int c = 0; c < 3; c++) step();
        control = 1'b0;
        step();
        chk("t4_drop_outs", outs(), 32'd0);
        chk("t4_drop_state", 32'(state_dbg), 32'(IDLE));
        control = 1'b1;
        step();
        chk("t4_rearm", outs(), pack(1'b0, 1'b1, 1'b0, 2'd3));
        for (int c = 0; c < 3; c++) begin
            step();
            chk("t4_fresh_gap", 32'(tick), 32'd0);
        end
        step();
        chk("t4_fresh_tick", outs(), pack(1'b1, 1'b1, 1'b0, 2'd2));

        // Test 5: reset mid-round with hold and control high
        step();
        rst = 1'b1;
        hold = 1'b1;
        step();
        chk("t5_reset_outs", outs(), 32'd0);
        chk("t5_reset_state", 32'(state_dbg), 32'(IDLE));
        rst = 1'b0;
        hold = 1'b0;
        step();
        chk("t5_rearm", outs(), pack(1'b0, 1'b1, 1'b0, 2'd3));
        for (int c = 0; c < 3; c++) begin
            step();
            chk("t5_gap", 32'(tick), 32'd0);
        end
        step();
        chk("t5_tick", outs(), pack(1'b1, 1'b1, 1'b0, 2'd2));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
